// File: rtl/multi_target_blanker_pkg.sv
// Shared definitions for the light-gun blanker: video bus layout, state
// encodings, colours and the enabled-target search helper.
package multi_target_blanker_pkg;

  // Bus layout, MSB first: {hcount[10:0], vcount[10:0], hsync, vsync, blank, rgb[11:0]}
  localparam int COORD_W   = 11;
  localparam int RGB_W     = 12;
  localparam int BUS_W     = 2 * COORD_W + 3 + RGB_W;
  localparam int BLANK_BIT = RGB_W;
  localparam int VSYNC_BIT = RGB_W + 1;
  localparam int HSYNC_BIT = RGB_W + 2;
  localparam int VC_LSB    = RGB_W + 3;
  localparam int HC_LSB    = VC_LSB + COORD_W;

  localparam int FCNT_W = 4;

  localparam logic [RGB_W-1:0] C_BLACK = 12'h000;
  localparam logic [RGB_W-1:0] C_WHITE = 12'hFFF;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_DARK    = 3'd2,
    S_FLASH   = 3'd3,
    S_DONE    = 3'd4,
    S_HOLDOFF = 3'd5
  } state_t;

  // Lowest set bit of en at or above index 'from'; result is {found, index}.
  function automatic logic [3:0] next_enabled(input logic [7:0] en, input int from);
    logic [3:0] res;
    res = '0;
    for (int k = 7; k >= 0; k--) begin
      if (k >= from && en[k]) res = {1'b1, 3'(k)};
    end
    return res;
  endfunction

  function automatic logic is_blanking(input state_t s);
    return (s == S_DARK) || (s == S_FLASH);
  endfunction

endpackage

// File: rtl/multi_target_blanker_box_match.sv
// Combinational point-in-box test; sums are widened to 12 bits so a box whose
// left/top edge sits near 2047 extends past the raster instead of wrapping to 0.
module box_match
  import multi_target_blanker_pkg::*;
#(
  parameter int BOX_WIDTH  = 64,
  parameter int BOX_HEIGHT = 64
) (
  input  logic [COORD_W-1:0] i_hcount,
  input  logic [COORD_W-1:0] i_vcount,
  input  logic [COORD_W-1:0] i_box_x,
  input  logic [COORD_W-1:0] i_box_y,
  output logic               o_inside
);

  logic [COORD_W:0] w_h;
  logic [COORD_W:0] w_v;
  logic [COORD_W:0] w_x0;
  logic [COORD_W:0] w_y0;
  logic [COORD_W:0] w_x1;
  logic [COORD_W:0] w_y1;

  assign w_h  = {1'b0, i_hcount};
  assign w_v  = {1'b0, i_vcount};
  assign w_x0 = {1'b0, i_box_x};
  assign w_y0 = {1'b0, i_box_y};
  assign w_x1 = w_x0 + (COORD_W + 1)'(BOX_WIDTH);
  assign w_y1 = w_y0 + (COORD_W + 1)'(BOX_HEIGHT);

  assign o_inside = (w_h >= w_x0) && (w_h < w_x1) && (w_v >= w_y0) && (w_v < w_y1);

endmodule

// File: rtl/multi_target_blanker.sv
// Inline video-bus blanker for light-gun hit detection: dark frames after a
// shot, then one white box per enabled target while sampling the photodiode.
module multi_target_blanker
  import multi_target_blanker_pkg::*;
#(
  parameter int N_TARGETS      = 2,
  parameter int BOX_WIDTH      = 64,
  parameter int BOX_HEIGHT     = 64,
  parameter int DARK_FRAMES    = 1,
  parameter int FLASH_FRAMES   = 1,
  parameter int HOLDOFF_FRAMES = 4
) (
  input  logic                     pclk,
  input  logic                     rst,
  input  logic [BUS_W-1:0]         video_bus_in,
  output logic [BUS_W-1:0]         video_bus_out,
  input  logic [11*N_TARGETS-1:0]  x_pos,
  input  logic [11*N_TARGETS-1:0]  y_pos,
  input  logic [N_TARGETS-1:0]     target_en,
  input  logic                     trigger_n,
  input  logic                     light,
  input  logic                     calib,
  output logic                     blanking,
  output logic                     busy,
  output logic [N_TARGETS-1:0]     hit,
  output logic                     shot_done
);

  localparam logic [FCNT_W-1:0] L_DARK_LAST  = FCNT_W'(DARK_FRAMES - 1);
  localparam logic [FCNT_W-1:0] L_FLASH_LAST = FCNT_W'(FLASH_FRAMES - 1);
  localparam logic [FCNT_W-1:0] L_HOLD_LAST  = FCNT_W'(HOLDOFF_FRAMES - 1);

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [FCNT_W-1:0]          r_fcnt;
  logic [FCNT_W-1:0]          w_fcnt_nxt;
  logic [2:0]                 r_idx;
  logic [2:0]                 w_idx_nxt;
  logic [11*N_TARGETS-1:0]    r_x;
  logic [11*N_TARGETS-1:0]    r_y;
  logic [N_TARGETS-1:0]       r_en;
  logic [N_TARGETS-1:0]       r_hit_acc;
  logic [N_TARGETS-1:0]       r_hit;
  logic                       r_cheat;
  logic                       r_trig_prev;
  logic                       r_vs_prev;
  logic                       r_busy;
  logic                       r_blank;
  logic                       r_shot_done;
  logic [BUS_W-1:RGB_W]       r_sync_p1;
  logic [RGB_W-1:0]           r_rgb_p1;

  logic                       w_vsync;
  logic                       w_frame_edge;
  logic                       w_trig_edge;
  logic [COORD_W-1:0]         w_hc;
  logic [COORD_W-1:0]         w_vc;
  logic [RGB_W-1:0]           w_rgb_in;
  logic [RGB_W-1:0]           w_rgb_nxt;
  logic [7:0]                 w_en8;
  logic [3:0]                 w_first;
  logic [3:0]                 w_after;
  logic [COORD_W-1:0]         w_bx;
  logic [COORD_W-1:0]         w_by;
  logic                       w_in_box;
  logic [N_TARGETS-1:0]       w_idx_bit;

  assign w_vsync      = video_bus_in[VSYNC_BIT];
  assign w_hc         = video_bus_in[HC_LSB +: COORD_W];
  assign w_vc         = video_bus_in[VC_LSB +: COORD_W];
  assign w_rgb_in     = video_bus_in[RGB_W-1:0];
  assign w_frame_edge = r_vs_prev & ~w_vsync;
  assign w_trig_edge  = r_trig_prev & ~trigger_n;
  assign w_en8        = 8'(r_en);
  assign w_first      = next_enabled(w_en8, 0);
  assign w_after      = next_enabled(w_en8, int'(r_idx) + 1);
  assign w_idx_bit    = N_TARGETS'(1) << r_idx;

  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    w_idx_nxt   = r_idx;
    if (calib) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_trig_edge) w_state_nxt = S_ARM;
        S_ARM: if (w_frame_edge) begin
          w_state_nxt = S_DARK;
          w_fcnt_nxt  = '0;
        end
        S_DARK: if (w_frame_edge) begin
          if (r_fcnt == L_DARK_LAST) begin
            w_fcnt_nxt = '0;
            if (w_first[3]) begin
              w_state_nxt = S_FLASH;
              w_idx_nxt   = w_first[2:0];
            end else begin
              w_state_nxt = S_DONE;
            end
          end else begin
            w_fcnt_nxt = r_fcnt + 1'b1;
          end
        end
        S_FLASH: if (w_frame_edge) begin
          if (r_fcnt == L_FLASH_LAST) begin
            w_fcnt_nxt = '0;
            if (w_after[3]) w_idx_nxt = w_after[2:0];
            else            w_state_nxt = S_DONE;
          end else begin
            w_fcnt_nxt = r_fcnt + 1'b1;
          end
        end
        S_DONE: begin
          w_fcnt_nxt  = '0;
          w_state_nxt = (HOLDOFF_FRAMES == 0) ? S_IDLE : S_HOLDOFF;
        end
        S_HOLDOFF: if (w_frame_edge) begin
          if (r_fcnt == L_HOLD_LAST) w_state_nxt = S_IDLE;
          else                       w_fcnt_nxt  = r_fcnt + 1'b1;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // The box drawn this pixel belongs to the target selected for the next state.
  always_comb begin
    w_bx = '0;
    w_by = '0;
    for (int k = 0; k < N_TARGETS; k++) begin
      if (w_idx_nxt == 3'(k)) begin
        w_bx = r_x[11*k +: 11];
        w_by = r_y[11*k +: 11];
      end
    end
  end

  box_match #(
    .BOX_WIDTH  (BOX_WIDTH),
    .BOX_HEIGHT (BOX_HEIGHT)
  ) u_box_match (
    .i_hcount (w_hc),
    .i_vcount (w_vc),
    .i_box_x  (w_bx),
    .i_box_y  (w_by),
    .o_inside (w_in_box)
  );

  always_comb begin
    w_rgb_nxt = w_rgb_in;
    if (calib) begin
      w_rgb_nxt = light ? C_WHITE : C_BLACK;
    end else begin
      case (w_state_nxt)
        S_DARK:  w_rgb_nxt = C_BLACK;
        S_FLASH: w_rgb_nxt = w_in_box ? C_WHITE : C_BLACK;
        default: w_rgb_nxt = w_rgb_in;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_fcnt      <= '0;
      r_idx       <= '0;
      r_hit       <= '0;
      r_hit_acc   <= '0;
      r_cheat     <= 1'b0;
      r_shot_done <= 1'b0;
      r_busy      <= 1'b0;
      r_blank     <= 1'b0;
      r_trig_prev <= 1'b1;
      r_vs_prev   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_fcnt      <= w_fcnt_nxt;
      r_idx       <= w_idx_nxt;
      r_trig_prev <= trigger_n;
      r_vs_prev   <= w_vsync;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_blank     <= is_blanking(w_state_nxt);
      r_shot_done <= !calib && (r_state == S_DONE);
      if (!calib) begin
        case (r_state)
          S_IDLE: if (w_trig_edge) begin
            r_hit_acc <= '0;
            r_cheat   <= 1'b0;
          end
          S_DARK:  if (light) r_cheat <= 1'b1;
          S_FLASH: if (light) r_hit_acc <= r_hit_acc | w_idx_bit;
          S_DONE:  r_hit <= r_cheat ? '0 : r_hit_acc;
          default: ;
        endcase
      end
    end
  end

  // Target geometry is frozen at the shot so mid-test edits cannot move a box.
  always_ff @(posedge pclk) begin
    if (!rst && !calib && r_state == S_IDLE && w_trig_edge) begin
      r_x  <= x_pos;
      r_y  <= y_pos;
      r_en <= target_en;
    end
  end

  // Output stage p1: sync/count fields are a plain one-pixel delay.
  always_ff @(posedge pclk) begin
    r_sync_p1 <= video_bus_in[BUS_W-1:RGB_W];
    if (rst) r_rgb_p1 <= C_BLACK;
    else     r_rgb_p1 <= w_rgb_nxt;
  end

  assign video_bus_out = {r_sync_p1, r_rgb_p1};
  assign blanking      = r_blank;
  assign busy          = r_busy;
  assign hit           = r_hit;
  assign shot_done     = r_shot_done;

endmodule

// File: tb/tb_multi_target_blanker.sv
// Directed scenarios with randomised pixels/colours, checked every cycle
// against a frame-level behavioural model of the blanker.
module tb_multi_target_blanker;

  localparam int NT = 2;
  localparam int BW = 64;
  localparam int BH = 64;
  localparam int DF = 1;
  localparam int FF = 1;
  localparam int HF = 4;
  localparam int P_IDLE = 0, P_ARM = 1, P_DARK = 2, P_FLASH = 3, P_DONE = 4, P_HOLD = 5;

  logic            pclk = 1'b0;
  logic            rst;
  logic [36:0]     video_bus_in;
  logic [36:0]     video_bus_out;
  logic [21:0]     x_pos;
  logic [21:0]     y_pos;
  logic [1:0]      target_en;
  logic            trigger_n;
  logic            light;
  logic            calib;
  logic            blanking;
  logic            busy;
  logic [1:0]      hit;
  logic            shot_done;

  always #5 pclk = ~pclk;

  multi_target_blanker #(
    .N_TARGETS(NT), .BOX_WIDTH(BW), .BOX_HEIGHT(BH),
    .DARK_FRAMES(DF), .FLASH_FRAMES(FF), .HOLDOFF_FRAMES(HF)
  ) dut (
    .pclk(pclk), .rst(rst), .video_bus_in(video_bus_in), .video_bus_out(video_bus_out),
    .x_pos(x_pos), .y_pos(y_pos), .target_en(target_en), .trigger_n(trigger_n),
    .light(light), .calib(calib), .blanking(blanking), .busy(busy), .hit(hit),
    .shot_done(shot_done)
  );

  logic [10:0] hc, vc;
  logic        hs, vs, bl;
  logic [11:0] rgb_in;
  logic [10:0] tx [2];
  logic [10:0] ty [2];
  logic [1:0]  ten;
  int          light_mode;

  int          m_phase, m_left;
  int          m_q[$];
  logic        m_cheat, m_prev_trig, m_prev_vs;
  logic [1:0]  m_acc, m_hit;
  int          lx [2];
  int          ly [2];
  logic [36:0] e_bus;
  logic        e_busy, e_blank, e_done;

  int   errors, checks, shots, fe_total, done_fe, hold_meas, base, white_ok, white_bad;
  bit   tracking, bound_mode;
  logic [1:0] last_hit, held;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    video_bus_in = {hc, vc, hs, vs, bl, rgb_in};
    x_pos = {tx[1], tx[0]};
    y_pos = {ty[1], ty[0]};
    target_en = ten;
    case (light_mode)
      0: light = 1'b0;
      1: light = 1'b1;
      2: light = (m_phase == P_FLASH && m_q.size() > 0 && m_q[0] == 1);
      default: light = 1'($urandom % 2);
    endcase
  endtask

  // Reference model: phase of the shot, frames left in the phase, and the
  // queue of targets still to be flashed.
  task automatic model();
    logic fe, te;
    logic [11:0] e_rgb;
    int t;
    fe = m_prev_vs && !vs;
    te = m_prev_trig && !trigger_n;
    e_done = 1'b0;
    e_rgb = rgb_in;
    if (rst) begin
      m_phase = P_IDLE; m_hit = '0; m_prev_trig = 1'b1; m_prev_vs = 1'b0; e_rgb = 12'h000;
    end else begin
      if (fe) fe_total++;
      if (calib) begin
        m_phase = P_IDLE;
        e_rgb = light ? 12'hFFF : 12'h000;
      end else begin
        case (m_phase)
          P_IDLE: if (te) begin
            for (int k = 0; k < 2; k++) begin lx[k] = int'(tx[k]); ly[k] = int'(ty[k]); end
            m_q.delete();
            for (int k = 0; k < 2; k++) if (ten[k]) m_q.push_back(k);
            m_acc = '0; m_cheat = 1'b0; m_phase = P_ARM;
          end
          P_ARM: if (fe) begin m_phase = P_DARK; m_left = DF; end
          P_DARK: begin
            if (light) m_cheat = 1'b1;
            if (fe) begin
              m_left--;
              if (m_left == 0) begin
                if (m_q.size() > 0) begin m_phase = P_FLASH; m_left = FF; end
                else m_phase = P_DONE;
              end
            end
          end
          P_FLASH: begin
            if (light) m_acc[m_q[0]] = 1'b1;
            if (fe) begin
              m_left--;
              if (m_left == 0) begin
                void'(m_q.pop_front());
                if (m_q.size() > 0) m_left = FF;
                else m_phase = P_DONE;
              end
            end
          end
          P_DONE: begin
            m_hit = m_cheat ? 2'b00 : m_acc;
            e_done = 1'b1;
            if (HF == 0) m_phase = P_IDLE;
            else begin m_phase = P_HOLD; m_left = HF; end
          end
          default: if (fe) begin
            m_left--;
            if (m_left == 0) m_phase = P_IDLE;
          end
        endcase
        if (m_phase == P_DARK) e_rgb = 12'h000;
        else if (m_phase == P_FLASH) begin
          t = m_q[0];
          e_rgb = (int'(hc) >= lx[t] && int'(hc) < lx[t] + BW &&
                   int'(vc) >= ly[t] && int'(vc) < ly[t] + BH) ? 12'hFFF : 12'h000;
        end
      end
      m_prev_trig = trigger_n;
      m_prev_vs = vs;
    end
    e_bus = {hc, vc, hs, vs, bl, e_rgb};
    e_busy = (m_phase != P_IDLE);
    e_blank = (m_phase == P_DARK || m_phase == P_FLASH);
  endtask

  task automatic cycle();
    apply();
    model();
    @(posedge pclk);
    #1;
    chk("bus", 64'(video_bus_out), 64'(e_bus));
    chk("busy", 64'(busy), 64'(e_busy));
    chk("blanking", 64'(blanking), 64'(e_blank));
    chk("shot_done", 64'(shot_done), 64'(e_done));
    chk("hit", 64'(hit), 64'(m_hit));
    if (shot_done === 1'b1) begin
      shots++; last_hit = hit; done_fe = fe_total; tracking = 1'b1;
    end else if (tracking && busy === 1'b0) begin
      hold_meas = fe_total - done_fe; tracking = 1'b0;
    end
    if (bound_mode && blanking === 1'b1 && video_bus_out[11:0] === 12'hFFF) begin
      if (video_bus_out[36:26] < 11'd2040) white_bad++;
      else white_ok++;
    end
  endtask

  task automatic pick_pixel();
    int t, v;
    rgb_in = 12'($urandom);
    hs = 1'($urandom);
    bl = 1'($urandom);
    if ($urandom_range(0, 3) == 0) begin
      hc = 11'($urandom); vc = 11'($urandom);
    end else begin
      t = bound_mode ? 1 : int'($urandom_range(0, 1));
      if (bound_mode) v = int'(tx[t]) - 8 + int'($urandom_range(0, 23));
      else            v = int'(tx[t]) - 4 + int'($urandom_range(0, 71));
      hc = 11'(v);
      v = int'(ty[t]) - 4 + int'($urandom_range(0, 71));
      vc = 11'(v);
    end
  endtask

  // One 34-cycle frame: 32 active pixels then 2 vsync-high cycles.
  task automatic frame(input int tf = -1, input int cf = -1, input int ct = -1, input int ra = -1);
    int save_mode;
    save_mode = light_mode;
    for (int i = 0; i < 34; i++) begin
      pick_pixel();
      vs = (i >= 32);
      trigger_n = !(tf >= 0 && i >= tf && i < tf + 2);
      calib = (i >= cf && i < ct);
      rst = (i == ra);
      light_mode = calib ? 3 : save_mode;
      cycle();
    end
    light_mode = save_mode; calib = 1'b0; rst = 1'b0; trigger_n = 1'b1;
  endtask

  initial begin
    errors = 0; checks = 0; shots = 0; fe_total = 0; done_fe = 0; hold_meas = -1;
    tracking = 1'b0; bound_mode = 1'b0; white_ok = 0; white_bad = 0; last_hit = '0;
    m_phase = P_IDLE; m_left = 0; m_cheat = 1'b0; m_acc = '0; m_hit = '0;
    m_prev_trig = 1'b1; m_prev_vs = 1'b0; lx = '{0, 0}; ly = '{0, 0};
    tx[0] = 11'd100; tx[1] = 11'd400; ty[0] = 11'd50; ty[1] = 11'd300; ten = 2'b11;
    rst = 1'b1; calib = 1'b0; trigger_n = 1'b1; light_mode = 0;

    for (int i = 0; i < 3; i++) begin pick_pixel(); vs = 1'b1; cycle(); end
    rst = 1'b0;
    repeat (2) frame();
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_hit", 64'(hit), 64'(0));

    // Two targets, light only during target 1's flash window
    light_mode = 2; base = shots;
    frame(5);
    repeat (9) frame();
    chk("two_tgt_shots", 64'(shots - base), 64'(1));
    chk("two_tgt_hit", 64'(last_hit), 64'(2'b10));
    chk("two_tgt_holdoff", 64'(hold_meas), 64'(4));

    // Light held for the whole shot
    light_mode = 1; base = shots;
    frame(5);
    repeat (9) frame();
    chk("cheat_shots", 64'(shots - base), 64'(1));
    chk("cheat_hit", 64'(last_hit), 64'(2'b00));

    // Only target 1 enabled, box at the right raster edge
    tx[1] = 11'd2040; ty[1] = 11'd0; ten = 2'b10; light_mode = 2; bound_mode = 1'b1; base = shots;
    frame(5);
    repeat (8) frame();
    bound_mode = 1'b0;
    chk("edge_shots", 64'(shots - base), 64'(1));
    chk("edge_hit", 64'(last_hit), 64'(2'b10));
    chk("edge_white_wrap", 64'(white_bad), 64'(0));
    chk("edge_white_seen", 64'(white_ok > 0), 64'(1));

    // Trigger on the frame edge, then a second pull during DARK
    tx[1] = 11'd400; ty[1] = 11'd300; ten = 2'b11; light_mode = 2; base = shots;
    frame(0);
    frame(10);
    repeat (8) frame();
    chk("coinc_shots", 64'(shots - base), 64'(1));
    chk("coinc_hit", 64'(last_hit), 64'(2'b10));

    // Calibration entered during the first flash frame
    held = hit; base = shots;
    frame(5);
    frame();
    frame(-1, 3, 25);
    repeat (6) frame();
    chk("calib_shots", 64'(shots - base), 64'(0));
    chk("calib_hit_held", 64'(hit), 64'(held));
    chk("calib_idle", 64'(busy), 64'(0));

    // Reset during the first flash frame
    base = shots;
    frame(5);
    frame();
    frame(-1, -1, -1, 10);
    repeat (3) frame();
    chk("rst_shots", 64'(shots - base), 64'(0));
    chk("rst_hit", 64'(hit), 64'(0));
    chk("rst_idle", 64'(busy), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_target_blanker.md
Name: multi_target_blanker

Overview:
- Light-gun hit-detection blanker for N on-screen targets.
- After a trigger pull it blacks out the screen for a programmable number of frames (anti-cheat check), then flashes each enabled target's box white in turn, one target per flash window.
- It samples the gun light sensor during each window to build a per-target hit vector.
- Sits inline on the video bus between the sprite/background mixer and the VGA output stage.

Parameters:
- N_TARGETS, 2, number of target boxes (1..8)
- BOX_WIDTH, 64, box width in pixels
- BOX_HEIGHT, 64, box height in pixels
- DARK_FRAMES, 1, all-black frames before the first flash (1..15)
- FLASH_FRAMES, 1, frames each target box is shown white (1..15)
- HOLDOFF_FRAMES, 4, pass-through frames after a result before re-arming (0..15)

Ports:
- pclk  in  1  pixel clock; the only clock
- rst  in  1  synchronous, active-high reset
- video_bus_in  in  `BUS_WIDTH+1  incoming video bus (hcount, vcount, hsync, vsync, blank, rgb)
- video_bus_out  out  `BUS_WIDTH+1  outgoing video bus; rgb replaced while testing
- x_pos  in  11*N_TARGETS  packed target left edges; target k occupies [11k+10:11k]
- y_pos  in  11*N_TARGETS  packed target top edges, same packing
- target_en  in  N_TARGETS  target k takes part in the test when 1
- trigger_n  in  1  gun trigger, active-low; a shot is the 1->0 edge
- light  in  1  gun photodiode, 1 = light detected
- calib  in  1  calibration mode
- blanking  out  1  1 while in DARK or FLASH
- busy  out  1  1 in any state other than IDLE
- hit  out  N_TARGETS  result of the last shot; held until the next result
- shot_done  out  1  one-pclk pulse when hit is updated

Behaviour:
- Reset: state=IDLE; hit=0, shot_done=0, blanking=0, busy=0; internal trigger/vsync history=1/0.
- video_bus_out:
  - Registered; every non-rgb field is video_bus_in delayed by exactly 1 pclk.
  - After reset the first cycle outputs rgb=0; rgb_in passes through from the next cycle.
- Frame edge: falling edge of vsync (previous vsync=1, current vsync=0).
- Trigger edge: previous trigger_n=1, current trigger_n=0. Trigger edges outside IDLE are ignored.
- States:
  - IDLE: rgb pass-through. On trigger edge, latch x_pos, y_pos and target_en, clear hit_acc and cheat, go to ARM.
  - ARM: rgb pass-through. On the next frame edge (never the same cycle as the trigger edge), go to DARK with frame_cnt=0.
  - DARK: rgb=12'h000 on every pixel. light=1 on any cycle sets cheat. Each frame edge increments frame_cnt. When frame_cnt reaches DARK_FRAMES:
    - if any latched enable is set, go to FLASH with idx = lowest enabled index;
    - otherwise go to DONE.
  - FLASH: rgb=12'hFFF when latched_x[idx] <= hcount < latched_x[idx]+BOX_WIDTH and the same test holds for vcount/y; otherwise 12'h000.
    - Compares use 12-bit sums, so boxes near 2047 never wrap.
    - light=1 sets hit_acc[idx].
    - After FLASH_FRAMES frame edges, go to the next higher enabled idx (frame_cnt=0), or to DONE if none remain.
  - DONE: one cycle. hit <= cheat ? 0 : hit_acc; shot_done=1; rgb pass-through. Go to HOLDOFF, or to IDLE when HOLDOFF_FRAMES=0.
  - HOLDOFF: rgb pass-through. Return to IDLE after HOLDOFF_FRAMES frame edges.
- blanking and busy are registered from the next state and align with the rgb they describe.
- calib=1:
  - Overrides everything; state is forced to IDLE.
  - rgb_out = light ? 12'hFFF : 12'h000 on every pixel.
  - hit is held; shot_done=0; blanking=0.
  - On release, normal operation resumes from IDLE.
- rst=1 mid-test aborts at once: no shot_done, hit cleared, pass-through on the following cycle.
- Changes to x_pos, y_pos or target_en during a test have no effect until the next shot.

Decomposition:
- Header multi_target_blanker.vh holds:
  - state encodings: IDLE, ARM, DARK, FLASH, DONE, HOLDOFF (3-bit);
  - colour constants C_BLACK=12'h000 and C_WHITE=12'hFFF;
  - the frame-counter width (4).
- One sub-module, box_match: combinational hcount/vcount-inside-box test with 12-bit arithmetic, parameterised by BOX_WIDTH/BOX_HEIGHT; instantiated once, fed by the idx mux.

Test Plan:
- Reset and pass-through: rst for 3 cycles, then random rgb_in. Expect hit=0, busy=0, rgb_out = rgb_in delayed 1 pclk, and all sync/count fields delayed 1.
- Two-target hit on target 1 only:
  - Setup: target_en=2'b11, x_pos={11'd400, 11'd100}, y_pos={11'd300, 11'd50}, light pulsed only while the target-1 box is drawn.
  - Expect: 1 dark frame, target 0 box at (100,50) in frame 2, target 1 box at (400,300) in frame 3.
  - Then shot_done once, hit=2'b10, busy low 4 frame edges later.
- Cheat: light held 1 for the entire shot. Expect hit=2'b00 and shot_done asserted.
- Disabled target and boundary:
  - Setup: target_en=2'b10, x=2040, y=0.
  - Expect: only one flash frame; white pixels exactly at hcount 2040..2047 with no wrap; hit[0]=0.
- Trigger edge coincident with a frame edge, and a second trigger edge while busy: DARK starts at the following frame edge, and the second edge is ignored (exactly one shot_done).
- calib and rst mid-FLASH:
  - calib=1 with light toggling: every pixel follows light (12'hFFF/12'h000) and state is IDLE.
  - rst during FLASH: no shot_done, hit=0, pass-through resumes.
